// File: rtl/twofish_mod_pkg.sv
// Shared definitions for the Twofish-modified decryption slice.
// Contents: block/key/round-index widths, controller state enum, and the
// byte-lane helpers that map a 32-bit block onto datapath lanes in1..in4
// (in1 = bits 31:24, in4 = bits 7:0).
package twofish_mod_pkg;

  localparam int unsigned BLOCK_W = 32;
  localparam int unsigned KEY_W   = 256;
  localparam int unsigned RIDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // lane 1..4 selects datapath input in1..in4
  function automatic logic [7:0] lane_byte(input logic [BLOCK_W-1:0] blk,
                                           input int unsigned lane);
    return blk[(4 - lane) * 8 +: 8];
  endfunction

  function automatic logic [BLOCK_W-1:0] pack_lanes(input logic [7:0] in1,
                                                    input logic [7:0] in2,
                                                    input logic [7:0] in3,
                                                    input logic [7:0] in4);
    return {in1, in2, in3, in4};
  endfunction

endpackage

// File: rtl/dec_round_timer.sv
// Round latency timer for dec_round_seq.
// Down-counter reloaded with ROUND_LAT-1 when a block is accepted and at every
// round boundary; round_done_o pulses on the last cycle of each round.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   load_i       block accepted, (re)start the first round
//   en_i         controller is running rounds
//   round_done_o last cycle of the current round
module dec_round_timer #(
  parameter int unsigned ROUND_LAT = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic round_done_o
);

  localparam int unsigned CW = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(ROUND_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      if (cnt_q == '0) cnt_d = RELOAD;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign round_done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/dec_round_seq.sv
// Iterative controller for the single-round decryption datapath.
// Accepts a block + key, drives the external round datapath NUM_ROUNDS times
// (each round held ROUND_LAT cycles, output fed back as next input) and
// returns the final block over a valid/ready handshake.
// Ports:
//   clk, rst                 clock, async active-low reset
//   start_valid/start_ready  block input handshake (din, key_in)
//   dout_valid/dout_ready    result handshake (dout)
//   busy                     high in RUN or DONE
//   rnd_data_o/rnd_key/rnd_r datapath inputs (in1..in4, key, round index)
//   rnd_data_i               datapath output (out1..out4)
module dec_round_seq
  import twofish_mod_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter int unsigned ROUND_LAT  = 6,
  parameter bit          DESCEND    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [BLOCK_W-1:0]  din,
  input  logic [KEY_W-1:0]    key_in,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [BLOCK_W-1:0]  dout,
  output logic                busy,
  output logic [BLOCK_W-1:0]  rnd_data_o,
  output logic [KEY_W-1:0]    rnd_key,
  output logic [RIDX_W-1:0]   rnd_r,
  input  logic [BLOCK_W-1:0]  rnd_data_i
);

  localparam logic [RIDX_W-1:0] LAST_RND = RIDX_W'(NUM_ROUNDS - 1);

  seq_state_e           state_q, state_d;
  logic [BLOCK_W-1:0]   data_q, data_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [RIDX_W-1:0]    rcnt_q, rcnt_d;
  logic [RIDX_W-1:0]    ridx_q, ridx_d;
  logic                 load;
  logic                 round_done;

  function automatic logic [RIDX_W-1:0] ridx_of(input logic [RIDX_W-1:0] c);
    return DESCEND ? (LAST_RND - c) : c;
  endfunction

  dec_round_timer #(
    .ROUND_LAT (ROUND_LAT)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst),
    .load_i       (load),
    .en_i         (state_q == RUN),
    .round_done_o (round_done)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    rcnt_d  = rcnt_q;
    ridx_d  = ridx_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d = RUN;
          data_d  = din;
          key_d   = key_in;
          rcnt_d  = '0;
          ridx_d  = ridx_of('0);
          load    = 1'b1;
        end
      end
      RUN: begin
        if (round_done) begin
          data_d = rnd_data_i;
          if (rcnt_q == LAST_RND) begin
            state_d = DONE;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
            ridx_d = ridx_of(rcnt_q + 1'b1);
          end
        end
      end
      DONE: begin
        if (dout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      key_q   <= '0;
      rcnt_q  <= '0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      rcnt_q  <= rcnt_d;
      ridx_q  <= ridx_d;
    end
  end

  // Lane order is identity: in1 takes bits 31:24, in4 takes bits 7:0.
  assign rnd_data_o  = pack_lanes(lane_byte(data_q, 1), lane_byte(data_q, 2),
                                  lane_byte(data_q, 3), lane_byte(data_q, 4));
  assign rnd_key     = key_q;
  assign rnd_r       = ridx_q;
  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign dout_valid  = (state_q == DONE);
  assign dout        = (state_q == DONE) ? data_q : '0;

endmodule

// File: tb/tb_dec_round_seq.sv
module tb_dec_round_seq;

  localparam int unsigned N1 = 16, L1 = 6;
  localparam int unsigned N2 = 5,  L2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // primary DUT (defaults, descending rounds)
  logic         rst = 1'b0, start_valid = 1'b0, dout_ready = 1'b0;
  logic         start_ready, dout_valid, busy;
  logic [31:0]  din = '0, dout, rnd_data_o, rnd_data_i;
  logic [255:0] key_in = '0, rnd_key;
  logic [3:0]   rnd_r;

  // secondary DUT (short, ascending rounds)
  logic         b_rst = 1'b0, b_start_valid = 1'b0, b_dout_ready = 1'b0;
  logic         b_start_ready, b_dout_valid, b_busy;
  logic [31:0]  b_din = '0, b_dout, b_rnd_data_o, b_rnd_data_i;
  logic [255:0] b_key_in = '0, b_rnd_key;
  logic [3:0]   b_rnd_r;

  dec_round_seq u_dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .din(din), .key_in(key_in), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout(dout), .busy(busy), .rnd_data_o(rnd_data_o), .rnd_key(rnd_key),
    .rnd_r(rnd_r), .rnd_data_i(rnd_data_i)
  );

  dec_round_seq #(.NUM_ROUNDS(N2), .ROUND_LAT(L2), .DESCEND(1'b0)) u_dut_asc (
    .clk(clk), .rst(b_rst), .start_valid(b_start_valid), .start_ready(b_start_ready),
    .din(b_din), .key_in(b_key_in), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
    .dout(b_dout), .busy(b_busy), .rnd_data_o(b_rnd_data_o), .rnd_key(b_rnd_key),
    .rnd_r(b_rnd_r), .rnd_data_i(b_rnd_data_i)
  );

  // Stub datapaths: out = in + 1 through ROUND_LAT-1 register stages, so the
  // result for a round's input is present exactly at that round's capture edge.
  logic [31:0] pipe1 [L1-1];
  logic [31:0] pipe2 [L2-1];
  always @(posedge clk) begin
    pipe1[0] <= rnd_data_o + 32'd1;
    for (int i = 1; i < int'(L1) - 1; i++) pipe1[i] <= pipe1[i-1];
    pipe2[0] <= b_rnd_data_o + 32'd1;
    for (int i = 1; i < int'(L2) - 1; i++) pipe2[i] <= pipe2[i-1];
  end
  assign rnd_data_i   = pipe1[L1-2];
  assign b_rnd_data_i = pipe2[L2-2];

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: after k stub rounds the block is din + k; round index follows
  // the configured direction.
  function automatic logic [3:0] exp_ridx(input int unsigned n, input bit desc, input int unsigned k);
    return desc ? 4'(n - 1 - k) : 4'(k);
  endfunction

  // Per-cycle log of datapath inputs while the primary DUT is running rounds.
  logic [31:0] log_d[$];
  logic [3:0]  log_r[$];
  always @(negedge clk)
    if (rst && busy && !dout_valid) begin
      log_d.push_back(rnd_data_o);
      log_r.push_back(rnd_r);
    end

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block1(input logic [31:0] d, input logic [255:0] k,
                            input int hold, input bit poke);
    int cyc;
    logic [31:0] exp;
    log_d.delete();
    log_r.delete();
    @(negedge clk);
    chk("start_ready_idle", start_ready, 1);
    start_valid = 1'b1; din = d; key_in = k;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start_valid = 1'b0; din = $urandom; key_in = rand_key();
    while (!dout_valid && cyc < 1000) begin
      if (cyc == 10) dout_ready = 1'b1;      // early ready must be ignored
      if (cyc == 60) dout_ready = 1'b0;
      if (poke && cyc == 20) begin start_valid = 1'b1; din = 32'hFFFF_FFFF; end
      if (poke && cyc == 25) begin
        chk("start_ready_run", start_ready, 0);
        chk("busy_run", busy, 1);
      end
      if (poke && cyc == 30) start_valid = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    exp = d + N1;
    chk("latency", cyc, N1 * L1 + 1);
    chk("dout", dout, exp);
    chk("key_held", rnd_key, k);
    chk("log_len", log_d.size(), N1 * L1);
    for (int i = 0; i < log_d.size(); i++) begin
      chk("rnd_data_o", log_d[i], d + 32'(i / int'(L1)));
      chk("rnd_r", log_r[i], exp_ridx(N1, 1'b1, i / L1));
    end
    repeat (hold) @(negedge clk);
    chk("dout_hold", dout, exp);
    chk("valid_hold", dout_valid, 1);
    chk("start_ready_done", start_ready, 0);
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dout_ready = 1'b0;
    chk("start_ready_after", start_ready, 1);
    chk("valid_after", dout_valid, 0);
    chk("busy_after", busy, 0);
    chk("dout_after", dout, 0);
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_start_ready"}, start_ready, 1);
    chk({pfx, "_dout_valid"}, dout_valid, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_dout"}, dout, 0);
    chk({pfx, "_rnd_r"}, rnd_r, 0);
    chk({pfx, "_rnd_data_o"}, rnd_data_o, 0);
    chk({pfx, "_rnd_key"}, rnd_key, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    reset_checks("rst0");
    chk("asc_rst_ready", b_start_ready, 1);
    chk("asc_rst_r", b_rnd_r, 0);
    fork
      begin : primary
        @(negedge clk);
        rst = 1'b1;
        run_block1(32'h0000_0000, 256'h0, 20, 1'b0);
        run_block1($urandom, rand_key(), 3, 1'b1);
        // abort mid-run: reset must act without a clock edge
        @(negedge clk);
        start_valid = 1'b1; din = $urandom; key_in = rand_key();
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (39) @(posedge clk);
        #2 rst = 1'b0;
        #1 reset_checks("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        for (int b = 0; b < 3; b++) run_block1($urandom, rand_key(), b, 1'b0);
      end
      begin : ascending
        int cyc, idx;
        logic [31:0] d;
        @(negedge clk);
        b_rst = 1'b1;
        for (int b = 0; b < 3; b++) begin
          d = $urandom;
          @(negedge clk);
          b_start_valid = 1'b1; b_din = d; b_key_in = rand_key();
          @(posedge clk);
          cyc = 1; idx = 0;
          @(negedge clk);
          b_start_valid = 1'b0;
          while (!b_dout_valid && cyc < 500) begin
            chk("asc_rnd_r", b_rnd_r, exp_ridx(N2, 1'b0, idx / L2));
            chk("asc_data", b_rnd_data_o, d + 32'(idx / int'(L2)));
            idx++;
            @(posedge clk);
            cyc++;
            @(negedge clk);
          end
          chk("asc_latency", cyc, N2 * L2 + 1);
          chk("asc_dout", b_dout, d + N2);
          b_dout_ready = 1'b1;
          @(posedge clk);
          @(negedge clk);
          b_dout_ready = 1'b0;
          chk("asc_start_ready", b_start_ready, 1);
        end
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
